// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller, its two requesters (IF, MEM) and the byte-wide RAM.
// Handshake: a requester raises req and holds it, with stable inputs, until its one-cycle done pulse; the controller samples req only while idle, and done is never asserted for the requester that did not own the transfer.
interface mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_done_o;
   logic [31:0]       if_inst_o;

   logic              mem_req_i;
   logic              mem_wr_i;
   logic [1:0]        mem_size_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [31:0]       mem_wdata_i;
   logic              mem_done_o;
   logic [31:0]       mem_rdata_o;

   logic [ADDR_W-1:0] ram_a_o;
   logic              ram_wr_o;
   logic [7:0]        ram_dout_o;
   logic [7:0]        ram_din_i;

   logic              busy_o;
   logic [1:0]        state_dbg;

   modport slave (
      input  if_req_i, if_addr_i,
      input  mem_req_i, mem_wr_i, mem_size_i, mem_addr_i, mem_wdata_i,
      input  ram_din_i,
      output if_done_o, if_inst_o,
      output mem_done_o, mem_rdata_o,
      output ram_a_o, ram_wr_o, ram_dout_o,
      output busy_o, state_dbg
   );

   modport master (
      output if_req_i, if_addr_i,
      output mem_req_i, mem_wr_i, mem_size_i, mem_addr_i, mem_wdata_i,
      output ram_din_i,
      input  if_done_o, if_inst_o,
      input  mem_done_o, mem_rdata_o,
      input  ram_a_o, ram_wr_o, ram_dout_o,
      input  busy_o, state_dbg
   );
endinterface

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage, sequencing
// little-endian multi-byte reads and writes one byte per cycle with MEM given priority.
module mem_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int IF_BYTES = 4
) (
   input logic           clk,
   input logic           rst,
   mem_ctrl_if.slave     bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   logic              owner_if;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wdata;
   logic [31:0]       acc;
   logic [3:0]        n_bytes;
   logic [3:0]        cnt;

   logic [3:0]        j;
   logic [ADDR_W-1:0] next_a;
   logic [1:0]        rd_idx;
   logic [1:0]        wr_idx;
   logic [31:0]       cap_word;
   logic [7:0]        wr_byte;

   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         default: return 4'd4;
      endcase
   endfunction

   // j is the index of the edge being processed, counted from the accept edge (E0).
   assign j      = cnt + 4'd1;
   assign next_a = base + ADDR_W'(j);
   assign rd_idx = 2'(j - 4'd2);
   assign wr_idx = 2'(j);

   // Byte for addr+k arrives on ram_din_i two edges after addr+k was issued.
   always_comb begin
      cap_word                  = acc;
      cap_word[{rd_idx, 3'b000} +: 8] = bus.ram_din_i;
   end

   assign wr_byte       = wdata[{wr_idx, 3'b000} +: 8];
   assign bus.busy_o    = (state != S_IDLE);
   assign bus.state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         owner_if        <= 1'b0;
         base            <= '0;
         wdata           <= '0;
         acc             <= '0;
         n_bytes         <= '0;
         cnt             <= '0;
         bus.if_done_o   <= 1'b0;
         bus.if_inst_o   <= '0;
         bus.mem_done_o  <= 1'b0;
         bus.mem_rdata_o <= '0;
         bus.ram_a_o     <= '0;
         bus.ram_wr_o    <= 1'b0;
         bus.ram_dout_o  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               acc <= '0;
               if (bus.mem_req_i) begin
                  owner_if    <= 1'b0;
                  base        <= bus.mem_addr_i;
                  wdata       <= bus.mem_wdata_i;
                  n_bytes     <= size_bytes(bus.mem_size_i);
                  bus.ram_a_o <= bus.mem_addr_i;
                  if (bus.mem_wr_i) begin
                     state          <= S_WRITE;
                     bus.ram_wr_o   <= 1'b1;
                     bus.ram_dout_o <= bus.mem_wdata_i[7:0];
                  end else begin
                     state <= S_READ;
                  end
               end else if (bus.if_req_i) begin
                  owner_if    <= 1'b1;
                  base        <= bus.if_addr_i;
                  n_bytes     <= 4'(IF_BYTES);
                  bus.ram_a_o <= bus.if_addr_i;
                  state       <= S_READ;
               end
            end

            S_READ: begin
               cnt <= cnt + 4'd1;
               if (j < n_bytes) begin
                  bus.ram_a_o <= next_a;
               end
               if (j == n_bytes + 4'd1) begin
                  state <= S_DONE;
                  if (owner_if) begin
                     bus.if_done_o <= 1'b1;
                     bus.if_inst_o <= cap_word;
                  end else begin
                     bus.mem_done_o  <= 1'b1;
                     bus.mem_rdata_o <= cap_word;
                  end
               end else if (j >= 4'd2) begin
                  acc <= cap_word;
               end
            end

            S_WRITE: begin
               if (j < n_bytes) begin
                  cnt            <= cnt + 4'd1;
                  bus.ram_a_o    <= next_a;
                  bus.ram_dout_o <= wr_byte;
                  bus.ram_wr_o   <= 1'b1;
               end else begin
                  bus.ram_wr_o   <= 1'b0;
                  bus.mem_done_o <= 1'b1;
                  state          <= S_DONE;
               end
            end

            S_DONE: begin
               // A still-high req is deliberately ignored here; it is taken on the next IDLE edge.
               bus.if_done_o  <= 1'b0;
               bus.mem_done_o <= 1'b0;
               state          <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
